// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM fetch arbiter.
// Port IDs, response-state encoding and bus widths.
package rom_arb_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STARVE_W = 4;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_e;

  typedef enum logic [1:0] {
    IDLE,
    RESP_IF,
    RESP_D
  } resp_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  function automatic logic is_unaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of consecutive cycles a requester is denied; limit_hit at LIMIT.
// Latency: count updates on the clock edge, limit_hit is a decode of the count.
// Backpressure: none; clears whenever the request drops or is granted.
module rom_arb_starve_ctr
  import rom_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic limit_hit
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !req || gnt) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign limit_hit = (cnt == LIM);

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one combinational ROM between instruction fetch and data load; ROM_ARB_ERR_EN adds unaligned/unmapped error reporting.
// Latency: grant in cycle N, rvalid+rdata in N+1; one access per cycle; fetch starvation bounded by STARVE_LIMIT.
// Backpressure: requesters hold req/addr until gnt; the response side has no stall.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable
);

  logic             starve_hit;
  logic             if_win;
  logic             any_gnt;
  port_e            win_port;
  logic [31:0]      addr_q;
  resp_t            resp_d;
  resp_t            resp_q;
  resp_state_e      state_q;
  resp_state_e      state_d;

  rom_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .req       (if_req),
    .gnt       (if_gnt),
    .limit_hit (starve_hit)
  );

  // Data loads win by default; a starved fetch takes the next slot.
  always_comb begin
    if_win   = if_req && (starve_hit || !d_req);
    if_gnt   = !reset && if_win;
    d_gnt    = !reset && d_req && !if_win;
    any_gnt  = if_gnt || d_gnt;
    win_port = if_gnt ? PORT_IF : PORT_D;
  end

  // Without a grant the ROM keeps seeing the last address so its output is stable.
  always_comb begin
    rom_addr = addr_q;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (d_gnt) begin
      rom_addr = d_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else if (any_gnt) begin
      addr_q <= rom_addr;
    end
  end

`ifdef ROM_ARB_ERR_EN
  always_comb begin
    resp_d.data = rom_data;
    resp_d.err  = !rom_accessable;
    if (is_unaligned(rom_addr[1:0])) begin
      resp_d.data = '0;
      resp_d.err  = 1'b1;
    end
  end
`else
  logic unused_accessable;
  assign unused_accessable = rom_accessable;

  always_comb begin
    resp_d.data = rom_data;
    resp_d.err  = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_q <= '0;
    end else if (any_gnt) begin
      resp_q <= resp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (any_gnt) begin
      state_d = (win_port == PORT_IF) ? RESP_IF : RESP_D;
    end
  end

  // Reset squashes a response already in flight.
  always_comb begin
    if_rvalid = (state_q == RESP_IF) && !reset;
    d_rvalid  = (state_q == RESP_D) && !reset;
    if_rdata  = resp_q.data;
    d_rdata   = resp_q.data;
    if_err    = if_rvalid && resp_q.err;
    d_err     = d_rvalid && resp_q.err;
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed cases then random traffic vs a behavioural model.
module tb_rom_fetch_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req;
  logic [31:0] if_addr, d_addr;
  logic        if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err;
  logic [31:0] if_rdata, d_rdata, rom_addr, rom_data;
  logic        rom_accessable;

  always #5 clk = ~clk;

  rom_fetch_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_accessable(rom_accessable)
  );

  // ROM image: 4 KiB window at 0x00400000, zero outside it.
  function automatic logic rom_acc(input logic [31:0] a);
    return (a >= 32'h0040_0000) && (a < 32'h0040_1000);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (!rom_acc(a)) return 32'h0;
    if (a == 32'h0040_0004) return 32'h2631_0000;
    return {~a[15:0], a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  assign rom_data       = rom_word(rom_addr);
  assign rom_accessable = rom_acc(rom_addr);

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model state
  int          wait_cnt;
  logic        pend_vld, pend_if, cap_err;
  logic [31:0] cap_data, last_addr;
  logic        exp_if_g, exp_d_g;
  logic        obs_if_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da);
    logic [31:0] ea;
    logic        rv_if, rv_d, unal;
    reset = r; if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    @(negedge clk);
    exp_if_g = !r && ir && ((wait_cnt >= LIMIT) || !dr);
    exp_d_g  = !r && dr && !exp_if_g;
    ea       = exp_if_g ? ia : (exp_d_g ? da : last_addr);
    rv_if    = pend_vld && pend_if && !r;
    rv_d     = pend_vld && !pend_if && !r;
    obs_if_g = if_gnt;
    chk("if_gnt", if_gnt, exp_if_g);
    chk("d_gnt", d_gnt, exp_d_g);
    chk("rom_addr", rom_addr, ea);
    chk("if_rvalid", if_rvalid, rv_if);
    chk("d_rvalid", d_rvalid, rv_d);
    chk("if_rdata", if_rdata, cap_data);
    chk("d_rdata", d_rdata, cap_data);
    chk("if_err", if_err, rv_if && cap_err);
    chk("d_err", d_err, rv_d && cap_err);
    if (r) begin
      wait_cnt = 0; pend_vld = 0; cap_data = 0; cap_err = 0; last_addr = 0;
    end else begin
      wait_cnt = (ir && !exp_if_g) ? wait_cnt + 1 : 0;
      pend_vld = exp_if_g || exp_d_g;
      if (pend_vld) begin
        pend_if   = exp_if_g;
        last_addr = ea;
        unal      = (ea[1:0] != 2'b00);
`ifdef ROM_ARB_ERR_EN
        cap_data = unal ? 32'h0 : rom_word(ea);
        cap_err  = unal || !rom_acc(ea);
`else
        cap_data = rom_word(ea);
        cap_err  = 1'b0;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 32'h0000_1000 + ($urandom_range(0, 255) << 2);
    if (k == 1) return 32'h0040_0000 + ($urandom_range(0, 1023) << 2) + $urandom_range(1, 3);
    return 32'h0040_0000 + ($urandom_range(0, 1023) << 2);
  endfunction

  logic        ih, dh;
  logic [31:0] ia, da;

  initial begin
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; if_addr = '0; d_addr = '0;
    wait_cnt = 0; pend_vld = 0; pend_if = 0; cap_data = 0; cap_err = 0; last_addr = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then released with no traffic
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

    // Lone fetch and its response
    step(0, 1, 32'h0040_0004, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("if_rdata_const", if_rdata, 32'h2631_0000);

    // Both requesting continuously: fetch wins every fifth cycle
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 32'h0040_0100, 1, 32'h0040_0200 + (i << 2));
      chk("pattern_if_gnt", obs_if_g, (i % 5) == 4);
    end
    step(0, 0, 0, 0, 0);

    // Unmapped and unaligned loads
    step(0, 0, 0, 1, 32'h0000_1000);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0040_0002);
    step(0, 0, 0, 0, 0);

    // Reset right after a grant, with a request in the reset cycle
    step(0, 0, 0, 1, 32'h0040_0008);
    step(1, 1, 32'h0040_000c, 1, 32'h0040_0010);
    step(0, 0, 0, 0, 0);
    chk("post_reset_rom_addr", rom_addr, 32'h0);

    // Random traffic with the hold-until-granted protocol
    ih = 0; dh = 0; ia = 0; da = 0;
    for (int i = 0; i < 500; i++) begin
      if (!ih) begin
        ia = rnd_addr();
        ih = ($urandom_range(0, 2) != 0);
      end
      if (!dh) begin
        da = rnd_addr();
        dh = ($urandom_range(0, 2) != 0);
      end
      step($urandom_range(0, 59) == 0, ih, ia, dh, da);
      if (exp_if_g) ih = 0;
      if (exp_d_g) dh = 0;
    end
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
